axi4_sram_target: RTL and testbench

//  AXI4 slave backed by an inferred single-port synchronous SRAM.

---
 rtl/axi4_sram_target.sv | 185 ++++++++++++++++++
 tb/tb_axi4_sram_target.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_sram_target.sv
// AXI4 slave over an inferred single-port synchronous SRAM; one transaction at a time, INCR bursts up to 256 beats.
// Optional macro AXI4_SRAM_TARGET_DECERR_EN: addresses above the memory range return DECERR instead of aliasing.
module axi4_sram_target #(
    parameter int MEM_ADDR_BITS      = 10,
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH    = 32,
    parameter int AXI4_ID_WIDTH      = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] i_awaddr,
    input  logic [AXI4_ID_WIDTH-1:0]      i_awid,
    input  logic [7:0]                    i_awlen,
    input  logic                          i_awvalid,
    output logic                          o_awready,
    input  logic [AXI4_DATA_WIDTH-1:0]    i_wdata,
    input  logic [AXI4_DATA_WIDTH/8-1:0]  i_wstrb,
    input  logic                          i_wlast,
    input  logic                          i_wvalid,
    output logic                          o_wready,
    output logic [AXI4_ID_WIDTH-1:0]      o_bid,
    output logic [1:0]                    o_bresp,
    output logic                          o_bvalid,
    input  logic                          i_bready,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] i_araddr,
    input  logic [AXI4_ID_WIDTH-1:0]      i_arid,
    input  logic [7:0]                    i_arlen,
    input  logic                          i_arvalid,
    output logic                          o_arready,
    output logic [AXI4_DATA_WIDTH-1:0]    o_rdata,
    output logic [AXI4_ID_WIDTH-1:0]      o_rid,
    output logic [1:0]                    o_rresp,
    output logic                          o_rlast,
    output logic                          o_rvalid,
    input  logic                          i_rready
);
    // state     | meaning
    // S_IDLE    | waiting for AR/AW, arbitrating simultaneous requests
    // S_WR_DATA | accepting W beats of the current write burst
    // S_WR_RESP | presenting B until BREADY
    // S_RD_DATA | streaming R beats from the registered SRAM output
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WR_DATA = 2'd1;
    localparam logic [1:0] S_WR_RESP = 2'd2;
    localparam logic [1:0] S_RD_DATA = 2'd3;

    localparam int NBYTES = AXI4_DATA_WIDTH / 8;
    localparam int B      = $clog2(NBYTES);
    localparam int TOP    = MEM_ADDR_BITS + B;
    localparam int DEPTH  = 1 << MEM_ADDR_BITS;
    localparam logic [MEM_ADDR_BITS-1:0] IDX_ONE = 1;

    logic [AXI4_DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [AXI4_DATA_WIDTH-1:0] r_mem_q;
    logic [1:0]                 r_state;
    logic                       r_rd_first;
    logic [AXI4_ID_WIDTH-1:0]   r_id;
    logic [7:0]                 r_len;
    logic [MEM_ADDR_BITS-1:0]   r_idx;
    logic [8:0]                 r_beat;
    logic                       r_oob;
    logic                       r_bvalid;
    logic [1:0]                 r_bresp;
    logic                       r_rvalid;

    logic                       w_idle;
    logic                       w_grant_rd;
    logic                       w_grant_wr;
    logic                       w_w_hs;
    logic                       w_r_hs;
    logic                       w_in_burst;
    logic                       w_last_beat;
    logic                       w_mem_we;
    logic                       w_aw_oob;
    logic                       w_ar_oob;
    logic [MEM_ADDR_BITS-1:0]   w_rd_idx;
    logic                       w_unused;

`ifdef AXI4_SRAM_TARGET_DECERR_EN
    assign w_aw_oob = |i_awaddr[AXI4_ADDRESS_WIDTH-1:TOP];
    assign w_ar_oob = |i_araddr[AXI4_ADDRESS_WIDTH-1:TOP];
`else
    assign w_aw_oob = 1'b0;
    assign w_ar_oob = 1'b0;
`endif
    assign w_unused = ^{i_awaddr[AXI4_ADDRESS_WIDTH-1:TOP], i_awaddr[B-1:0],
                        i_araddr[AXI4_ADDRESS_WIDTH-1:TOP], i_araddr[B-1:0]};

    assign w_idle      = (r_state == S_IDLE);
    assign w_grant_rd  = i_arvalid && (r_rd_first || !i_awvalid);
    assign w_grant_wr  = i_awvalid && (!r_rd_first || !i_arvalid);
    assign o_arready   = w_idle && !rst_i && w_grant_rd;
    assign o_awready   = w_idle && !rst_i && w_grant_wr;
    assign o_wready    = (r_state == S_WR_DATA);
    assign w_w_hs      = o_wready && i_wvalid;
    assign w_r_hs      = r_rvalid && i_rready;
    assign w_in_burst  = (r_beat <= {1'b0, r_len});
    assign w_last_beat = (r_beat == {1'b0, r_len});
    // Beats past LEN and out-of-range bursts are acknowledged but never reach the array.
    assign w_mem_we    = w_w_hs && w_in_burst && !r_oob && !rst_i;
    // Pre-fetch the next word on a handshake so a held RREADY streams one beat per cycle.
    assign w_rd_idx    = w_idle ? i_araddr[TOP-1:B] : (w_r_hs ? r_idx + IDX_ONE : r_idx);

    assign o_bvalid = r_bvalid;
    assign o_bresp  = r_bresp;
    assign o_bid    = r_id;
    assign o_rvalid = r_rvalid;
    assign o_rid    = r_id;
    assign o_rlast  = r_rvalid && w_last_beat;
    assign o_rresp  = r_oob ? 2'b11 : 2'b00;
    assign o_rdata  = r_oob ? '0 : r_mem_q;

    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (i_wstrb[i]) r_mem[r_idx][i*8 +: 8] <= i_wdata[i*8 +: 8];
            end
        end
        r_mem_q <= r_mem[w_rd_idx];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_rd_first <= 1'b1;
            r_id       <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_beat     <= '0;
            r_oob      <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
            r_rvalid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_beat <= '0;
                    if (i_arvalid && i_awvalid) r_rd_first <= !r_rd_first;
                    if (o_arready) begin
                        r_id     <= i_arid;
                        r_len    <= i_arlen;
                        r_idx    <= i_araddr[TOP-1:B];
                        r_oob    <= w_ar_oob;
                        r_rvalid <= 1'b1;
                        r_state  <= S_RD_DATA;
                    end else if (o_awready) begin
                        r_id    <= i_awid;
                        r_len   <= i_awlen;
                        r_idx   <= i_awaddr[TOP-1:B];
                        r_oob   <= w_aw_oob;
                        r_state <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (w_w_hs) begin
                        r_idx <= r_idx + IDX_ONE;
                        if (w_in_burst) r_beat <= r_beat + 9'd1;
                        if (i_wlast) begin
                            r_bresp  <= r_oob ? 2'b11 : (w_last_beat ? 2'b00 : 2'b10);
                            r_bvalid <= 1'b1;
                            r_state  <= S_WR_RESP;
                        end
                    end
                end
                S_WR_RESP: begin
                    if (i_bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_RD_DATA: begin
                    if (w_r_hs) begin
                        r_idx  <= r_idx + IDX_ONE;
                        r_beat <= r_beat + 9'd1;
                        if (w_last_beat) begin
                            r_rvalid <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_sram_target.sv
// Randomized self-checking bench for axi4_sram_target against a word-array memory model.
// Define AXI4_SRAM_TARGET_DECERR_EN for both bench and design to exercise out-of-range responses.
module tb_axi4_sram_target;
`ifdef AXI4_SRAM_TARGET_DECERR_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] i_awaddr = '0;
    logic [3:0]  i_awid = '0;
    logic [7:0]  i_awlen = '0;
    logic        i_awvalid = 1'b0;
    logic        o_awready;
    logic [31:0] i_wdata = '0;
    logic [3:0]  i_wstrb = '0;
    logic        i_wlast = 1'b0;
    logic        i_wvalid = 1'b0;
    logic        o_wready;
    logic [3:0]  o_bid;
    logic [1:0]  o_bresp;
    logic        o_bvalid;
    logic        i_bready = 1'b0;
    logic [31:0] i_araddr = '0;
    logic [3:0]  i_arid = '0;
    logic [7:0]  i_arlen = '0;
    logic        i_arvalid = 1'b0;
    logic        o_arready;
    logic [31:0] o_rdata;
    logic [3:0]  o_rid;
    logic [1:0]  o_rresp;
    logic        o_rlast;
    logic        o_rvalid;
    logic        i_rready = 1'b0;

    logic [31:0] mdl [0:1023];
    int n_chk = 0;
    int n_fail = 0;
    int seq = 0;
    int ar_seq = 0;
    int aw_seq = 0;

    axi4_sram_target dut (
        .clk_i(clk), .rst_i(rst_i),
        .i_awaddr(i_awaddr), .i_awid(i_awid), .i_awlen(i_awlen), .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid), .o_wready(o_wready),
        .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
        .i_araddr(i_araddr), .i_arid(i_arid), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rdata(o_rdata), .o_rid(o_rid), .o_rresp(o_rresp), .o_rlast(o_rlast), .o_rvalid(o_rvalid),
        .i_rready(i_rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_oob(input logic [31:0] addr);
        return DEC && (addr[31:12] != 20'h0);
    endfunction

    task automatic aw_hs(input logic [31:0] addr, input logic [3:0] id, input int len);
        int n = 0;
        logic hs = 1'b0;
        i_awaddr = addr; i_awid = id; i_awlen = 8'(len); i_awvalid = 1'b1;
        while (!hs && n < 300) begin
            @(negedge clk); hs = o_awready;
            @(posedge clk); #1; n++;
        end
        aw_seq = seq++;
        i_awvalid = 1'b0;
        if (!hs) chk("aw timeout", 0, 1);
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic last);
        int n = 0;
        logic hs = 1'b0;
        i_wdata = d; i_wstrb = s; i_wlast = last; i_wvalid = 1'b1;
        while (!hs && n < 50) begin
            @(negedge clk); hs = o_wready;
            @(posedge clk); #1; n++;
        end
        i_wvalid = 1'b0; i_wlast = 1'b0;
        if (!hs) chk("w timeout", 0, 1);
    endtask

    task automatic b_wait(input logic [3:0] id, input logic [1:0] er);
        int n = 0;
        logic hs = 1'b0;
        i_bready = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        i_bready = 1'b1;
        while (!hs && n < 50) begin
            @(negedge clk); hs = o_bvalid;
            if (hs) begin
                chk("bid", o_bid, id);
                chk("bresp", o_bresp, er);
            end
            @(posedge clk); #1; n++;
        end
        i_bready = 1'b0;
        if (!hs) chk("b timeout", 0, 1);
        @(negedge clk); chk("b drop", o_bvalid, 0);
        @(posedge clk); #1;
    endtask

    function automatic void mdl_put(input int w, input logic [31:0] d, input logic [3:0] s);
        for (int k = 0; k < 4; k++) if (s[k]) mdl[w % 1024][k*8 +: 8] = d[k*8 +: 8];
    endfunction

    // nb = beat on which WLAST is driven, plus one; beats past len are expected to be dropped.
    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input int len, input int nb,
                            input bit drnd, input logic [31:0] d0, input bit srnd, input logic [3:0] s0);
        int idx;
        bit oob;
        logic [31:0] d;
        logic [3:0] s;
        logic [1:0] er;
        idx = int'(addr[11:2]);
        oob = is_oob(addr);
        aw_hs(addr, id, len);
        for (int b = 0; b < nb; b++) begin
            d = drnd ? $urandom : d0 + 32'(b);
            s = srnd ? 4'($urandom_range(0, 15)) : s0;
            w_beat(d, s, b == nb - 1);
            if (b <= len && !oob) mdl_put(idx + b, d, s);
        end
        er = oob ? 2'b11 : ((nb - 1 == len) ? 2'b00 : 2'b10);
        b_wait(id, er);
    endtask

    // mode 0: RREADY held high, 1: random RREADY, 2: RREADY pattern 1,0,0,...
    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input int len, input int mode);
        int n = 0;
        int b = 0;
        int c = 0;
        int idx;
        bit oob;
        logic hs = 1'b0;
        idx = int'(addr[11:2]);
        oob = is_oob(addr);
        i_araddr = addr; i_arid = id; i_arlen = 8'(len); i_arvalid = 1'b1;
        while (!hs && n < 300) begin
            @(negedge clk); hs = o_arready;
            @(posedge clk); #1; n++;
        end
        ar_seq = seq++;
        i_arvalid = 1'b0;
        if (!hs) chk("ar timeout", 0, 1);
        while (hs && b <= len && c < 3000) begin
            i_rready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (c % 3 == 0);
            @(negedge clk);
            if (c == 0) chk("r first", o_rvalid, 1);
            if (o_rvalid) begin
                chk("rdata", o_rdata, oob ? 32'h0 : mdl[(idx + b) % 1024]);
                chk("rid", o_rid, id);
                chk("rresp", o_rresp, oob ? 2'b11 : 2'b00);
                chk("rlast", o_rlast, b == len);
                if (i_rready) b++;
            end
            @(posedge clk); #1; c++;
        end
        i_rready = 1'b0;
        if (b <= len) chk("r timeout", 0, 1);
        @(negedge clk); chk("r end", o_rvalid, 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outs", {o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_rlast, o_bresp, o_rresp}, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before 2ms");
        $fatal(1);
    end

    initial begin
        logic [31:0] addr;
        int len;
        int nb;
        do_reset();
        for (int k = 0; k < 4; k++) do_write(32'(k * 1024), 4'h0, 255, 256, 1'b1, 0, 1'b0, 4'hF);
        do_reset();

        // arbitration right after reset: read, then write, then read again
        fork
            do_read(32'h40, 4'h1, 0, 0);
            do_write(32'h44, 4'h2, 0, 1, 1'b1, 0, 1'b0, 4'hF);
        join
        chk("arb 1 read", ar_seq < aw_seq, 1);
        fork
            do_read(32'h48, 4'h3, 1, 0);
            do_write(32'h4C, 4'h4, 1, 2, 1'b1, 0, 1'b0, 4'hF);
        join
        chk("arb 2 write", aw_seq < ar_seq, 1);
        fork
            do_read(32'h50, 4'h5, 0, 1);
            do_write(32'h54, 4'h6, 0, 1, 1'b1, 0, 1'b0, 4'hF);
        join
        chk("arb 3 read", ar_seq < aw_seq, 1);

        do_write(32'h100, 4'h3, 3, 4, 1'b0, 32'hA0, 1'b0, 4'hF);
        do_read(32'h100, 4'h9, 3, 0);
        do_write(32'h20, 4'h1, 0, 1, 1'b0, 32'hFFFF_FFFF, 1'b0, 4'hF);
        do_write(32'h20, 4'h1, 0, 1, 1'b0, 32'h1122_3344, 1'b0, 4'h5);
        do_read(32'h20, 4'h2, 0, 0);
        chk("strb merge", mdl[8], 32'hFF22_FF44);
        do_read(32'h200, 4'hA, 7, 2);
        do_write(32'h300, 4'h2, 3, 2, 1'b1, 0, 1'b0, 4'hF);
        do_write(32'h340, 4'h2, 1, 4, 1'b1, 0, 1'b0, 4'hF);
        do_read(32'h300, 4'h4, 3, 0);
        do_read(32'h340, 4'h4, 3, 0);
        do_write(32'hFF0, 4'hB, 7, 8, 1'b1, 0, 1'b1, 0);
        do_read(32'hFF0, 4'hC, 7, 1);
        do_read(32'h0000_5100, 4'hD, 3, 0);

        for (int i = 0; i < 60; i++) begin
            addr = {($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'h0,
                    10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3))};
            len = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len + 3) : len + 1;
                do_write(addr, 4'($urandom), len, nb, 1'b1, 0, 1'b1, 0);
            end else begin
                do_read(addr, 4'($urandom), len, $urandom_range(0, 2));
            end
        end

        // reset during beat 2 of an 8-beat write: beats 0 and 1 persist
        aw_hs(32'h600, 4'h7, 7);
        w_beat(32'hC0DE_0000, 4'hF, 1'b0);
        mdl_put(384, 32'hC0DE_0000, 4'hF);
        w_beat(32'hC0DE_0001, 4'hF, 1'b0);
        mdl_put(385, 32'hC0DE_0001, 4'hF);
        i_wdata = 32'hDEAD_BEEF; i_wstrb = 4'hF; i_wvalid = 1'b1; rst_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid rst outs", {o_awready, o_wready, o_bvalid, o_arready, o_rvalid}, 0);
        i_wvalid = 1'b0; rst_i = 1'b0;
        @(posedge clk); #1;
        do_read(32'h600, 4'h8, 7, 0);
        do_write(32'h700, 4'h5, 2, 3, 1'b1, 0, 1'b0, 4'hF);
        do_read(32'h700, 4'h5, 2, 2);
`ifdef AXI4_SRAM_TARGET_DECERR_EN
        do_read(32'h8000_0000, 4'h1, 3, 1);
        do_write(32'h8000_0100, 4'h2, 1, 1, 1'b1, 0, 1'b0, 4'hF);
        do_read(32'h100, 4'h3, 1, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
